regfile_write_arbiter: RTL and testbench

Sequencing and arbitration controller for the single write port of the 32 x 32-bit register bank built from REG32 cells. Two requesters share the port, for example ALU writeback and memory load, each using a valid/ready handshake. Each accepted write is registered once and driven to the bank as address, data and a one-hot per-register load vector. A sequenced CLEAR mode zeroes the whole bank through the same port.

---
 rtl/rfarb_pkg.sv | 15 +
 rtl/regfile_write_arbiter_if.sv | 35 +++
 rtl/rfarb_dec.sv | 19 +
 rtl/regfile_write_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/rfarb_pkg.sv
// Shared types and constants for the register-bank write arbiter.
package rfarb_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 5;

    // Register 0 reads as zero and is never loaded.
    localparam int ZERO_REG = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rfarb_state_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes, clear control and bank write port of the arbiter.
interface regfile_write_arbiter_if
    import rfarb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    localparam int NREG = 1 << AW;

    logic            V0;
    logic [AW-1:0]   A0;
    logic [DW-1:0]   D0;
    logic            RDY0;
    logic            V1;
    logic [AW-1:0]   A1;
    logic [DW-1:0]   D1;
    logic            RDY1;
    logic            CLR;
    logic            BUSY;
    logic            WE;
    logic [AW-1:0]   WA;
    logic [DW-1:0]   WD;
    logic [NREG-1:0] LD;

    modport master (
        output V0, A0, D0, V1, A1, D1, CLR,
        input  RDY0, RDY1, BUSY, WE, WA, WD, LD
    );

    modport slave (
        input  V0, A0, D0, V1, A1, D1, CLR,
        output RDY0, RDY1, BUSY, WE, WA, WD, LD
    );

endinterface

// File: rtl/rfarb_dec.sv
// Address to one-hot load-vector decoder; disabled or address 0 yields all zeros.
module rfarb_dec
    import rfarb_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic                en,
    input  logic [AW-1:0]       addr,
    output logic [(1<<AW)-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en && (addr != AW'(ZERO_REG))) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester write-port arbiter with sequenced bank clear for the REG32 bank.
// Define RFARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module regfile_write_arbiter
    import rfarb_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                  C,
    input  logic                  nR,
    regfile_write_arbiter_if.slave bus
);

    localparam int              NREG      = 1 << AW;
    localparam logic [AW-1:0]   ZERO_ADDR = AW'(ZERO_REG);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(NREG - 1);

    rfarb_state_e  state_q;
    rfarb_state_e  state_d;
    logic [AW-1:0] cnt_q;
    logic          gnt0;
    logic          gnt1;
    logic          clr_start;
    logic          clr_step;

    logic          we_p1;
    logic [AW-1:0] wa_p1;
    logic [DW-1:0] wd_p1;

`ifdef RFARB_RR_EN
    logic          ptr_q;
`endif

    assign clr_start = (state_q == ST_IDLE) && bus.CLR;
    assign clr_step  = (state_q == ST_CLEAR) && (cnt_q != LAST_ADDR);

    always_comb begin
        state_d = state_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.CLR) begin
                    state_d = ST_CLEAR;
                end else begin
`ifdef RFARB_RR_EN
                    if (bus.V0 && bus.V1) begin
                        gnt0 = ~ptr_q;
                        gnt1 = ptr_q;
                    end else begin
                        gnt0 = bus.V0;
                        gnt1 = bus.V1;
                    end
`else
                    gnt0 = bus.V0;
                    gnt1 = bus.V1 & ~bus.V0;
`endif
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Ready is forced low while reset is held so every output reads 0 in reset.
    assign bus.RDY0 = gnt0 & nR;
    assign bus.RDY1 = gnt1 & nR;
    assign bus.BUSY = (state_q == ST_CLEAR);

    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clr_start) begin
                cnt_q <= AW'(1);
            end else if (clr_step) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

`ifdef RFARB_RR_EN
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            ptr_q <= 1'b0;
        end else if (gnt0) begin
            ptr_q <= 1'b1;
        end else if (gnt1) begin
            ptr_q <= 1'b0;
        end
    end
`endif

    // ---- write stage (p1): registered bank port, one cycle after accept ----
    // The clear loads address 1 on the CLR edge so WA tracks CNT while in CLEAR.
    always_ff @(posedge C or negedge nR) begin
        if (!nR) begin
            we_p1 <= 1'b0;
            wa_p1 <= '0;
            wd_p1 <= '0;
        end else begin
            we_p1 <= 1'b0;
            if (clr_start) begin
                we_p1 <= 1'b1;
                wa_p1 <= AW'(1);
                wd_p1 <= '0;
            end else if (clr_step) begin
                we_p1 <= 1'b1;
                wa_p1 <= cnt_q + 1'b1;
                wd_p1 <= '0;
            end else if (gnt0) begin
                we_p1 <= (bus.A0 != ZERO_ADDR);
                wa_p1 <= bus.A0;
                wd_p1 <= bus.D0;
            end else if (gnt1) begin
                we_p1 <= (bus.A1 != ZERO_ADDR);
                wa_p1 <= bus.A1;
                wd_p1 <= bus.D1;
            end
        end
    end

    assign bus.WE = we_p1;
    assign bus.WA = wa_p1;
    assign bus.WD = wd_p1;

    rfarb_dec #(
        .AW (AW)
    ) u_dec (
        .en     (we_p1),
        .addr   (wa_p1),
        .onehot (bus.LD)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;

`ifdef RFARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    regfile_write_arbiter_if #(.DW(32), .AW(5)) bus ();

    regfile_write_arbiter #(.DW(32), .AW(5)) dut (
        .C   (clk),
        .nR  (rst_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected bank-port contents and the pending clear addresses.
    int          m_busy;
    int          m_we;
    int          m_wa;
    logic [31:0] m_wd;
    int          m_ptr;
    int          clr_q[$];

    // Observations taken inside the most recent cycle, for directed checks.
    logic        s_rdy0, s_rdy1, s_busy, s_we;
    logic [4:0]  s_wa;
    logic [31:0] s_wd, s_ld;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_we = 0; m_wa = 0; m_wd = '0; m_ptr = 0;
        clr_q.delete();
    endtask

    task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic clr);
        int win;
        logic [63:0] exp_ld;
        @(negedge clk);
        bus.V0 = v0; bus.A0 = a0; bus.D0 = d0;
        bus.V1 = v1; bus.A1 = a1; bus.D1 = d1;
        bus.CLR = clr;
        #1;
        win = -1;
        if (m_busy == 0 && !clr) begin
            if (v0 && v1)  win = RR ? m_ptr : 0;
            else if (v0)   win = 0;
            else if (v1)   win = 1;
        end
        exp_ld = (m_we != 0) ? (64'd1 << m_wa) : 64'd0;
        chk("rdy0", 64'(bus.RDY0), 64'(win == 0));
        chk("rdy1", 64'(bus.RDY1), 64'(win == 1));
        chk("busy", 64'(bus.BUSY), 64'(m_busy != 0));
        chk("we",   64'(bus.WE),   64'(m_we != 0));
        chk("ld",   64'(bus.LD),   exp_ld);
        if (m_we != 0) begin
            chk("wa", 64'(bus.WA), 64'(m_wa));
            chk("wd", 64'(bus.WD), 64'(m_wd));
        end
        s_rdy0 = bus.RDY0; s_rdy1 = bus.RDY1; s_busy = bus.BUSY;
        s_we = bus.WE; s_wa = bus.WA; s_wd = bus.WD; s_ld = bus.LD;
        @(posedge clk);
        if (m_busy != 0) begin
            if (clr_q.size() > 0) begin
                m_wa = clr_q.pop_front(); m_wd = '0; m_we = 1;
            end else begin
                m_busy = 0; m_we = 0;
            end
        end else if (clr) begin
            m_busy = 1;
            clr_q.delete();
            for (int a = 2; a < 32; a++) clr_q.push_back(a);
            m_we = 1; m_wa = 1; m_wd = '0;
        end else if (win >= 0) begin
            m_wa  = (win == 1) ? int'(a1) : int'(a0);
            m_wd  = (win == 1) ? d1 : d0;
            m_we  = (m_wa != 0) ? 1 : 0;
            m_ptr = 1 - win;
        end else begin
            m_we = 0;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    initial begin
        int n_busy;
        int g0, g1;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        bus.V0 = 0; bus.A0 = '0; bus.D0 = '0;
        bus.V1 = 0; bus.A1 = '0; bus.D1 = '0;
        bus.CLR = 0;
        model_reset();
        #2;
        chk("rst_we", 64'(bus.WE), 64'd0);
        chk("rst_wa", 64'(bus.WA), 64'd0);
        chk("rst_wd", 64'(bus.WD), 64'd0);
        chk("rst_ld", 64'(bus.LD), 64'd0);
        chk("rst_busy", 64'(bus.BUSY), 64'd0);
        chk("rst_rdy", 64'({bus.RDY0, bus.RDY1}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during a clear, on the 10th clear cycle.
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        for (int i = 0; i < 9; i++) idle();
        @(negedge clk);
        #1;
        chk("mid_busy_pre", 64'(bus.BUSY), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_we", 64'(bus.WE), 64'd0);
        chk("mid_wa", 64'(bus.WA), 64'd0);
        chk("mid_wd", 64'(bus.WD), 64'd0);
        chk("mid_ld", 64'(bus.LD), 64'd0);
        chk("mid_busy", 64'(bus.BUSY), 64'd0);
        bus.V1 = 1'b1;
        #1;
        chk("mid_rdy1_in_rst", 64'(bus.RDY1), 64'd0);
        bus.V1 = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1234_5678, 1'b0);
        chk("post_rst_rdy1", 64'(s_rdy1), 64'd1);

        // Contention for four cycles.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 5'd3, 32'hA000_0000 + 32'(i), 1'b1, 5'd7, 32'hB000_0000 + 32'(i), 1'b0);
            chk("cont_rdy0", 64'(s_rdy0), RR ? 64'((i % 2) == 0) : 64'd1);
        end

        // Single write and its one-cycle-later bank strobe.
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("sw_rdy0", 64'(s_rdy0), 64'd1);
        idle();
        chk("sw_we", 64'(s_we), 64'd1);
        chk("sw_wa", 64'(s_wa), 64'd5);
        chk("sw_wd", 64'(s_wd), 64'hDEAD_BEEF);
        chk("sw_ld", 64'(s_ld), 64'h20);
        idle();
        chk("sw_hold_we", 64'(s_we), 64'd0);
        chk("sw_hold_wa", 64'(s_wa), 64'd5);
        chk("sw_hold_wd", 64'(s_wd), 64'hDEAD_BEEF);

        // Write to hardwired-zero register.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        chk("r0_rdy1", 64'(s_rdy1), 64'd1);
        idle();
        chk("r0_we", 64'(s_we), 64'd0);
        chk("r0_ld", 64'(s_ld), 64'd0);

        // Clear sequence with a competing request on the CLR cycle.
        cycle(1'b1, 5'd4, 32'h5555_AAAA, 1'b0, 5'd0, 32'd0, 1'b1);
        chk("clr_rdy0", 64'(s_rdy0), 64'd0);
        for (int i = 1; i < 32; i++) begin
            cycle(1'b1, 5'd4, 32'h5555_AAAA, 1'b0, 5'd0, 32'd0, 1'b0);
            chk("clr_busy", 64'(s_busy), 64'd1);
            chk("clr_wa", 64'(s_wa), 64'(i));
            chk("clr_ld", 64'(s_ld), 64'd1 << i);
            chk("clr_rdy0_held", 64'(s_rdy0), 64'd0);
        end
        cycle(1'b1, 5'd4, 32'h5555_AAAA, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("clr_end_busy", 64'(s_busy), 64'd0);
        chk("clr_end_rdy0", 64'(s_rdy0), 64'd1);
        idle();

        // A second CLR during the clear must not restart it.
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'(i == 4));
            if (s_busy) n_busy++;
        end
        chk("clr_ign_len", 64'(n_busy), 64'd31);

        // Randomised traffic with occasional clears and address-0 writes.
        g0 = 0; g1 = 0;
        for (int i = 0; i < 1200; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                  1'($urandom_range(0, 59) == 0));
            if (s_rdy0) g0++;
            if (s_rdy1) g1++;
        end
        chk("rand_saw_grants", 64'((g0 > 0) && (g1 > 0)), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
